uart_byte_receiver: RTL and testbench

Serial front end of the program-load path. It samples the asynchronous UART_RX line, rejects glitches, and deframes 8N1 characters (LSB first). It presents each good byte on data with a one-cycle valid strobe to the instruction-assembly stage. data holds its value until the next good byte, so the consumer may latch it one or more cycles after valid.

---
 rtl/uart_byte_receiver.sv | 141 ++++++++++++++
 tb/tb_uart_byte_receiver.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver: synchronizes UART_RX, rejects glitches by 3-point majority
// sampling mid-bit, and emits each correctly framed byte with a one-cycle strobe.
module uart_byte_receiver #(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       UART_RX,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] C_HM1  = CW'(H - 1);
    localparam logic [CW-1:0] C_H    = CW'(H);
    localparam logic [CW-1:0] C_HP1  = CW'(H + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 8) begin : g_bad_cpb
            $error("CLKS_PER_BIT must be >= 8");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("SYNC_STAGES must be >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BRK
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [CW-1:0]          cnt;
    logic [2:0]             bit_idx;
    logic [1:0]             samp_q;
    logic [7:0]             shift_q;
    logic                   maj;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], UART_RX};
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Samples at H-1 and H are held; the third is the live rx_s at H+1.
    assign maj = (samp_q[0] & samp_q[1]) | (rx_s & (samp_q[0] | samp_q[1]));

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            samp_q    <= '0;
            shift_q   <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (cnt == C_HM1) samp_q[0] <= rx_s;
            if (cnt == C_H)   samp_q[1] <= rx_s;

            case (state)
                S_IDLE: begin
                    // The detection cycle itself is cnt 0 of the start bit.
                    if (!rx_s) begin
                        state <= S_START;
                        cnt   <= CW'(1);
                        busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt == C_HP1 && maj) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == C_LAST) begin
                        state   <= S_DATA;
                        cnt     <= '0;
                        bit_idx <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == C_HP1) shift_q[bit_idx] <= maj;
                    if (cnt == C_LAST) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) state   <= S_STOP;
                        else                 bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    // Leave at mid-stop so a back-to-back start edge is caught.
                    if (cnt == C_HP1) begin
                        cnt <= '0;
                        if (maj) begin
                            data  <= shift_q;
                            valid <= 1'b1;
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BRK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BRK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed bench for uart_byte_receiver at CLKS_PER_BIT=16: timing, glitch,
// framing error/break, back-to-back frames, majority vote and async reset.
module tb_uart_byte_receiver;

    localparam int CPB = 16;
    localparam int H   = CPB / 2;
    // Pin edge to valid: SYNC_STAGES + 9*CPB + H + 2
    localparam int LAT = 2 + 9 * CPB + H + 2;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       UART_RX = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int ncmp = 0;
    int nerr = 0;
    int cyc  = 0;
    int vcnt = 0;
    int fcnt = 0;
    int both = 0;
    int vcyc[$];
    logic [7:0] vdat[$];
    int fcyc = 0;

    uart_byte_receiver #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RSTN(RSTN), .UART_RX(UART_RX),
        .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (valid) begin
            vcnt++;
            vcyc.push_back(cyc);
            vdat.push_back(data);
        end
        if (frame_err) begin
            fcnt++;
            fcyc = cyc;
        end
        if (valid && frame_err) both++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Drives start, 8 data bits LSB first, stop. spike_bit selects a frame bit
    // (0=start, 1..8 data, 9 stop) that gets a one-cycle inversion at offset H.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int spike_bit);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < CPB; k++) begin
                UART_RX = (i == spike_bit && k == H) ? ~f[i] : f[i];
                tick(1);
            end
        end
    endtask

    initial begin
        int c0, v0, f0;

        tick(3);
        chk("rst_data", data, 8'h00);
        chk("rst_valid", valid, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        RSTN = 1'b1;
        tick(5);

        // Single byte, exact timing
        v0 = vcnt; c0 = cyc;
        send_frame(8'hA5, 1'b1, -1);
        UART_RX = 1'b1;
        tick(10);
        chk("a5_count", vcnt - v0, 1);
        chk("a5_data", data, 8'hA5);
        chk("a5_lat", vcyc[vcyc.size()-1] - c0, LAT);
        chk("a5_ferr", fcnt, 0);
        chk("a5_busy", busy, 1'b0);

        // 3-cycle start glitch
        v0 = vcnt;
        UART_RX = 1'b0;
        tick(3);
        UART_RX = 1'b1;
        tick(2);
        @(negedge CLK);
        chk("gl_busy_hi", busy, 1'b1);
        tick(40);
        chk("gl_count", vcnt - v0, 0);
        chk("gl_ferr", fcnt, 0);
        chk("gl_busy_lo", busy, 1'b0);
        chk("gl_data", data, 8'hA5);

        // Framing error followed by break, then recovery
        v0 = vcnt;
        send_frame(8'h3C, 1'b1, -1);
        UART_RX = 1'b1;
        tick(5);
        chk("3c_data", data, 8'h3C);
        c0 = cyc;
        send_frame(8'h5A, 1'b0, -1);
        UART_RX = 1'b0;
        tick(100);
        chk("fe_count", fcnt, 1);
        chk("fe_time", fcyc - c0, LAT);
        chk("fe_data", data, 8'h3C);
        chk("fe_valid", vcnt - v0, 1);
        chk("fe_busy", busy, 1'b1);
        UART_RX = 1'b1;
        tick(10);
        chk("brk_busy", busy, 1'b0);
        send_frame(8'hC3, 1'b1, -1);
        UART_RX = 1'b1;
        tick(10);
        chk("c3_data", data, 8'hC3);
        chk("c3_count", vcnt - v0, 2);
        chk("c3_ferr", fcnt, 1);

        // Four back-to-back 0xFF frames
        v0 = vcnt; c0 = cyc;
        for (int n = 0; n < 4; n++) send_frame(8'hFF, 1'b1, -1);
        UART_RX = 1'b1;
        tick(10);
        chk("ff_count", vcnt - v0, 4);
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("ff_time%0d", n), vcyc[v0+n] - c0, LAT + 10 * CPB * n);
            chk($sformatf("ff_data%0d", n), vdat[v0+n], 8'hFF);
        end

        // Spike at mid-bit of data bit 3
        v0 = vcnt;
        send_frame(8'h81, 1'b1, 4);
        UART_RX = 1'b1;
        tick(10);
        chk("sp_count", vcnt - v0, 1);
        chk("sp_data", data, 8'h81);

        // Async reset during data bit 4, held until the frame has passed
        fork
            send_frame(8'h55, 1'b1, -1);
            begin
                repeat (85) @(posedge CLK);
                #2;
                chk("ar_busy_pre", busy, 1'b1);
                RSTN = 1'b0;
                #1;
                chk("ar_data", data, 8'h00);
                chk("ar_busy", busy, 1'b0);
                chk("ar_valid", valid, 1'b0);
                chk("ar_ferr", frame_err, 1'b0);
            end
        join
        UART_RX = 1'b1;
        tick(2);
        RSTN = 1'b1;
        v0 = vcnt; f0 = fcnt;
        tick(30);
        chk("ar_quiet", vcnt - v0, 0);
        send_frame(8'h55, 1'b1, -1);
        UART_RX = 1'b1;
        tick(10);
        chk("ar55_count", vcnt - v0, 1);
        chk("ar55_data", data, 8'h55);
        chk("ar55_ferr", fcnt - f0, 0);

        chk("excl", both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
